// File: rtl/approx_wallace_accumulator.sv
// Carry-propagate adder and frame accumulator behind the approximate Wallace tree.
// Optional build macro ACC_SAT_EN: clamp the accumulator on overflow instead of wrapping.
module approx_wallace_accumulator #(
  parameter int ACC_W   = 24,
  parameter int N_TERMS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_sum,
  input  logic [15:0]      in_carry,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [7:0]       out_count,
  output logic             out_ovf
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer holds its data stable while valid is high and ready is low.

  localparam logic [7:0] N_TERMS_L = 8'(N_TERMS);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic             ovf;

  logic             accept;
  logic             close;
  logic [16:0]      prod;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_next;
  logic [7:0]       cnt_next;

  // Full 17-bit product from the two tree rows, zero-extended into the adder.
  assign prod     = {1'b0, in_sum} + {1'b0, in_carry};
  assign sum_ext  = {1'b0, acc} + {{(ACC_W-16){1'b0}}, prod};
  assign ovf_next = ovf | sum_ext[ACC_W];

`ifdef ACC_SAT_EN
  // Once overflowed, the value stays pinned at full scale for the rest of the frame.
  assign acc_next = ovf_next ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign acc_next = sum_ext[ACC_W-1:0];
`endif

  assign cnt_next = cnt + 8'd1;
  assign in_ready = (state == ACCUM);
  assign accept   = in_valid && in_ready;
  assign close    = in_last || (cnt_next == N_TERMS_L);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM: if (accept && close) state_next = DONE;
      DONE:  if (out_ready)       state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            cnt <= cnt_next;
            ovf <= ovf_next;
            if (close) begin
              out_acc   <= acc_next;
              out_count <= cnt_next;
              out_ovf   <= ovf_next;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule
